// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt controller.
// FSM encoding, register word offsets and CTRL bit positions.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h4;
  localparam logic [3:0] OFF_CAUSE = 4'h8;
  localparam logic [3:0] OFF_CTRL  = 4'hC;

  localparam int CTRL_EN = 0;
  localparam int CTRL_RR = 1;

endpackage

// File: rtl/irq_controller_prio_sel.sv
// Combinational winner picker for pending requests.
// Fixed mode scans from 0; round-robin scans from rr_ptr with wrap.
module irq_prio_sel
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req_vec,
  input  logic [2:0]         rr_ptr,
  input  logic               rr,
  output logic [2:0]         winner,
  output logic               any
);

  localparam logic [3:0] NS = 4'(NUM_SRC);

  logic [7:0] req8;
  logic [3:0] base;
  logic [3:0] idx;
  logic       found;

  assign req8 = 8'(req_vec);
  assign base = rr ? {1'b0, rr_ptr} : 4'd0;
  assign any  = |req_vec;

  // first set request at or after the start index, wrapping
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    idx    = 4'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = base + k[3:0];
      if (idx >= NS) idx = idx - NS;
      if (!found && req8[idx[2:0]]) begin
        found  = 1'b1;
        winner = idx[2:0];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Memory-mapped interrupt controller for the MIPS peripheral bus.
// Edge capture, masking, priority select and req/ack/service FSM.
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0030,
  parameter logic        RR_DEFAULT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src,
  input  logic               ker,
  input  logic               irq_ack,
  input  logic               rd,
  input  logic               wr,
  input  logic [31:0]        addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata,
  output logic               irqout,
  output logic [2:0]         cause_id
);

  localparam logic [3:0] NS = 4'(NUM_SRC);

  irq_state_t state, state_n;

  logic [NUM_SRC-1:0] pending, mask, src_d;
  logic [NUM_SRC-1:0] req_vec, events, w1c, clr;
  logic               ker_d, en, rr, cause_v;
  logic [2:0]         rr_ptr, winner;
  logic [3:0]         off, ptr_inc;
  logic               hit, wr_hit, any, take, ret;
  logic               unused_bits;

  assign hit     = addr[31:4] == BASE_ADDR[31:4];
  assign off     = {addr[3:2], 2'b00};
  assign wr_hit  = wr && hit;
  assign req_vec = pending & mask;
  assign events  = src & ~src_d;
  assign w1c     = (wr_hit && off == OFF_PEND)
                 ? wdata[NUM_SRC-1:0] : '0;
  assign clr     = take ? (NUM_SRC'(1) << winner) : '0;
  assign ptr_inc = {1'b0, winner} + 4'd1;
  assign unused_bits = ^{addr[1:0], wdata};

  irq_prio_sel #(.NUM_SRC(NUM_SRC)) u_sel (
    .req_vec(req_vec),
    .rr_ptr (rr_ptr),
    .rr     (rr),
    .winner (winner),
    .any    (any)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // next state plus ack/return strobes
  always_comb begin
    state_n = state;
    take    = 1'b0;
    ret     = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && any && !ker) state_n = REQ;
      end
      REQ: begin
        if (irq_ack && any) begin
          take    = 1'b1;
          state_n = SERVICE;
        end else if (!any || !en) begin
          state_n = IDLE;
        end
      end
      SERVICE: begin
        if (ker_d && !ker) begin
          ret     = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // datapath registers: pending, config, cause, history
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending  <= '0;
      mask     <= '0;
      src_d    <= '0;
      ker_d    <= 1'b0;
      en       <= 1'b0;
      rr       <= RR_DEFAULT;
      rr_ptr   <= 3'd0;
      cause_v  <= 1'b0;
      cause_id <= 3'd0;
      irqout   <= 1'b0;
    end else begin
      src_d   <= src;
      ker_d   <= ker;
      irqout  <= state_n == REQ;
      pending <= (pending & ~w1c & ~clr) | events;
      if (wr_hit && off == OFF_MASK)
        mask <= wdata[NUM_SRC-1:0];
      if (wr_hit && off == OFF_CTRL) begin
        en <= wdata[CTRL_EN];
        rr <= wdata[CTRL_RR];
      end
      if (take) begin
        cause_v  <= 1'b1;
        cause_id <= winner;
        rr_ptr   <= (ptr_inc == NS) ? 3'd0 : ptr_inc[2:0];
      end else if (ret) begin
        cause_v <= 1'b0;
      end
    end
  end

  // bus read mux, zero when not selected
  always_comb begin
    rdata = '0;
    if (rd && hit) begin
      unique case (off)
        OFF_PEND:  rdata = 32'(pending);
        OFF_MASK:  rdata = 32'(mask);
        OFF_CAUSE: rdata = {28'd0, cause_v, cause_id};
        OFF_CTRL: begin
          rdata[CTRL_EN] = en;
          rdata[CTRL_RR] = rr;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Randomized bench with a behavioural model of irq_controller.
// Directed scenarios first, then random traffic.
module tb_irq_controller;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h4000_0030;
  localparam logic [31:0] A_PEND  = BASE;
  localparam logic [31:0] A_MASK  = BASE + 4;
  localparam logic [31:0] A_CAUSE = BASE + 8;
  localparam logic [31:0] A_CTRL  = BASE + 12;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [N-1:0] src = '0;
  logic        ker = 1'b0;
  logic        irq_ack = 1'b0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irqout;
  logic [2:0]  cause_id;

  int total = 0;
  int bad = 0;

  // model state (mode: 0 idle, 1 requesting, 2 in service)
  int m_pend = 0, m_mask = 0, m_en = 0, m_rr = 0, m_ptr = 0;
  int m_cv = 0, m_cid = 0, m_mode = 0, m_srcd = 0, m_kerd = 0;

  irq_controller #(
    .NUM_SRC(N), .BASE_ADDR(BASE), .RR_DEFAULT(1'b0)
  ) dut (
    .clk(clk), .reset(reset), .src(src), .ker(ker),
    .irq_ack(irq_ack), .rd(rd), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .irqout(irqout),
    .cause_id(cause_id)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pick(int req);
    for (int k = 0; k < N; k++) begin
      int i;
      i = m_rr != 0 ? (m_ptr + k) % N : k;
      if (((req >> i) & 1) != 0) return i;
    end
    return 0;
  endfunction

  function automatic logic [31:0] m_read(logic [31:0] a);
    if ((a >> 4) != (BASE >> 4)) return 0;
    case (a[3:2])
      2'd0: return m_pend;
      2'd1: return m_mask;
      2'd2: return m_cv * 8 + m_cid;
      default: return m_rr * 2 + m_en;
    endcase
  endfunction

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_en = 0; m_rr = 0; m_ptr = 0;
    m_cv = 0; m_cid = 0; m_mode = 0; m_srcd = 0; m_kerd = 0;
  endtask

  task automatic m_step();
    int req, ev, w, np, hitw, o;
    req = m_pend & m_mask;
    ev = int'(src) & ~m_srcd & ((1 << N) - 1);
    hitw = (wr && (addr >> 4) == (BASE >> 4)) ? 1 : 0;
    o = int'(addr[3:2]);
    np = m_pend;
    if (hitw != 0 && o == 0) np = np & ~int'(wdata);
    case (m_mode)
      0: if (m_en != 0 && req != 0 && !ker) m_mode = 1;
      1: begin
        if (irq_ack && req != 0) begin
          w = pick(req);
          m_cv = 1; m_cid = w;
          np = np & ~(1 << w);
          m_ptr = (w + 1) % N;
          m_mode = 2;
        end else if (req == 0 || m_en == 0) m_mode = 0;
      end
      default: if (m_kerd != 0 && !ker) begin
        m_mode = 0; m_cv = 0;
      end
    endcase
    m_pend = (np | ev) & ((1 << N) - 1);
    if (hitw != 0 && o == 1) m_mask = int'(wdata) & ((1 << N) - 1);
    if (hitw != 0 && o == 3) begin
      m_en = int'(wdata[0]); m_rr = int'(wdata[1]);
    end
    m_srcd = int'(src);
    m_kerd = int'(ker);
  endtask

  task automatic cyc();
    #1;
    if (rd) chk("rdata", rdata, m_read(addr));
    if (!reset) m_reset(); else m_step();
    @(posedge clk);
    @(negedge clk);
    chk("irqout", 32'(irqout), (m_mode == 1) ? 1 : 0);
    chk("cause_id", 32'(cause_id), m_cid);
  endtask

  task automatic bus_wr(logic [31:0] a, logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    cyc();
    wr = 1'b0;
  endtask

  task automatic rd_is(string tag, logic [31:0] a, logic [31:0] exp);
    logic [31:0] v;
    addr = a; rd = 1'b1;
    #1 v = rdata;
    chk(tag, v, exp);
    cyc();
    rd = 1'b0;
  endtask

  task automatic wait_irq();
    for (int i = 0; i < 8 && !irqout; i++) cyc();
    chk("irq_wait", 32'(irqout), 1);
  endtask

  task automatic ack_enter();
    irq_ack = 1'b1; ker = 1'b1;
    cyc();
    irq_ack = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    cyc(); cyc();
    reset = 1'b1;

    // reset clears configured state
    bus_wr(A_MASK, 32'hF);
    bus_wr(A_CTRL, 32'h1);
    reset = 1'b0; cyc(); reset = 1'b1;
    rd_is("rst_pend", A_PEND, 0);
    rd_is("rst_mask", A_MASK, 0);
    rd_is("rst_cause", A_CAUSE, 0);
    rd_is("rst_ctrl", A_CTRL, 0);
    chk("rst_irq", 32'(irqout), 0);

    // single source round trip
    bus_wr(A_MASK, 32'h4);
    bus_wr(A_CTRL, 32'h1);
    src = 4'b0100; cyc(); src = '0;
    rd_is("t2_pend", A_PEND, 4);
    chk("t2_irq", 32'(irqout), 1);
    ack_enter();
    rd_is("t2_cause", A_CAUSE, 32'hA);
    rd_is("t2_pend0", A_PEND, 0);
    chk("t2_irq0", 32'(irqout), 0);
    ker = 1'b0; cyc();
    rd_is("t2_ret", A_CAUSE, 32'h2);

    // fixed priority
    bus_wr(A_MASK, 32'hF);
    src = 4'b1010; cyc(); src = '0;
    wait_irq();
    ack_enter();
    rd_is("fx_cause1", A_CAUSE, 32'h9);
    rd_is("fx_pend", A_PEND, 32'h8);
    ker = 1'b0; cyc();
    cyc();
    chk("fx_reirq", 32'(irqout), 1);
    ack_enter();
    rd_is("fx_cause2", A_CAUSE, 32'hB);
    ker = 1'b0; cyc();

    // round robin
    bus_wr(A_CTRL, 32'h3);
    src = 4'hF; cyc(); src = '0;
    for (int i = 0; i < 5; i++) begin
      wait_irq();
      ack_enter();
      rd_is("rr_cause", A_CAUSE, 32'(8 + i % 4));
      src = 4'(1 << (i % 4)); cyc(); src = '0;
      ker = 1'b0; cyc();
    end

    // W1C against event
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_PEND, 32'hF);
    rd_is("w1c_all", A_PEND, 0);
    addr = A_PEND; wdata = 32'h1; wr = 1'b1; src = 4'b0001;
    cyc();
    wr = 1'b0; src = '0;
    rd_is("coll_keep", A_PEND, 1);
    bus_wr(A_PEND, 32'h1);
    rd_is("w1c_clr", A_PEND, 0);
    bus_wr(A_CTRL, 32'h1);
    src = 4'b0001; cyc(); src = '0;
    wait_irq();
    bus_wr(A_PEND, 32'h1);
    cyc();
    chk("req_drop", 32'(irqout), 0);

    // kernel gating and nesting
    ker = 1'b1;
    src = 4'b0010; cyc(); src = '0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ker_gate", 32'(irqout), 0);
    end
    ker = 1'b0;
    wait_irq();
    ack_enter();
    src = 4'b0100; cyc(); src = '0;
    cyc(); cyc();
    chk("svc_block", 32'(irqout), 0);
    ker = 1'b0; cyc();
    chk("ret_idle", 32'(irqout), 0);
    cyc();
    chk("ret_req", 32'(irqout), 1);
    ack_enter();
    ker = 1'b0; cyc();
    rd_is("unmap1", 32'h4000_0040, 0);
    rd_is("unmap2", 32'h0000_0030, 0);

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      src = 4'($urandom);
      if ($urandom_range(0, 7) == 0) ker = ~ker;
      irq_ack = $urandom_range(0, 3) == 0;
      case ($urandom_range(0, 5))
        0: wr = 1'b1;
        1: rd = 1'b1;
        default: ;
      endcase
      if ($urandom_range(0, 9) == 0) addr = $urandom();
      else addr = {BASE[31:4], 2'($urandom), 2'b00};
      wdata = $urandom();
      cyc();
      wr = 1'b0; rd = 1'b0; irq_ack = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
